cache_ctrl_fsm: RTL and testbench

- Control state machine for the 2-way set-associative cache.
- Sequences the cache datapath using the per-set hit/way-select result from the hit logic: tag/valid/dirty/data array loads, LRU updates, writeback and line fill over the physical-memory port.
- Handshakes with the CPU port (mem_read/mem_write/mem_resp) and the physical-memory port (pmem_read/pmem_write/pmem_resp).
- Provides saturating performance counters.

---
 rtl/cache_ctrl_fsm.sv | 198 +++++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cache_ctrl_fsm
//
// Control state machine for a 2-way set-associative cache.
//
// It takes the per-set hit/way-select result from the hit logic and drives the
// cache datapath:
//   - tag, valid, dirty and data array loads
//   - LRU updates
//   - writeback of a dirty victim line and line fill over the physical-memory
//     port
//
// It also keeps saturating performance counters.
//
// Ports
//   i_clk, i_rst        clock (rising edge); asynchronous active-high reset
//
//   CPU side
//   i_mem_read          read request, held with its address until o_mem_resp
//   i_mem_write         write request, held with address/data until o_mem_resp
//   o_mem_resp          request complete, one-cycle pulse
//
//   Hit logic
//   i_hit               hit in the current set
//   i_way_sel           hit way on a hit, LRU victim way on a miss
//   i_valid_sel         valid bit of the selected way
//   i_dirty_sel         dirty bit of the selected way
//
//   Physical memory
//   o_pmem_read         line-fill request
//   o_pmem_write        writeback request
//   i_pmem_resp         transaction done, one-cycle pulse
//   o_pmem_addr_sel     0 = CPU address, 1 = victim (stored tag) address
//
//   Datapath control
//   o_load_data         write the data line of the selected way
//   o_data_src_sel      0 = line from pmem, 1 = CPU data merged by byte enable
//   o_load_tag          write the tag of the selected way
//   o_load_valid        set the valid bit of the selected way
//   o_set_dirty         set the dirty bit of the selected way
//   o_clr_dirty         clear the dirty bit of the selected way
//   o_load_lru          write the LRU bit of the current set
//   o_lru_in            LRU value to write (the way not just used)
//
//   Counters (saturating)
//   o_hit_count         requests completed as hits
//   o_miss_count        requests entering miss handling
//   o_wb_count          completed writebacks
// ---------------------------------------------------------------------------
module cache_ctrl_fsm #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    output logic                 o_mem_resp,
    input  logic                 i_hit,
    input  logic                 i_way_sel,
    input  logic                 i_valid_sel,
    input  logic                 i_dirty_sel,
    output logic                 o_pmem_read,
    output logic                 o_pmem_write,
    input  logic                 i_pmem_resp,
    output logic                 o_pmem_addr_sel,
    output logic                 o_load_data,
    output logic                 o_data_src_sel,
    output logic                 o_load_tag,
    output logic                 o_load_valid,
    output logic                 o_set_dirty,
    output logic                 o_clr_dirty,
    output logic                 o_load_lru,
    output logic                 o_lru_in,
    output logic [CNT_WIDTH-1:0] o_hit_count,
    output logic [CNT_WIDTH-1:0] o_miss_count,
    output logic [CNT_WIDTH-1:0] o_wb_count
);

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_hit_count;
    logic [CNT_WIDTH-1:0] r_miss_count;
    logic [CNT_WIDTH-1:0] r_wb_count;

    logic w_req;
    logic w_req_hit;
    logic w_req_miss;

    // A simultaneous read and write is handled as a write, which is why only
    // i_mem_write is consulted for the write-specific controls below.
    assign w_req      = i_mem_read | i_mem_write;
    assign w_req_hit  = w_req & i_hit;
    assign w_req_miss = w_req & ~i_hit;

    // Outputs are combinational so a hit completes in the same cycle the
    // request is seen. Reset forces everything low, so a pmem transaction or
    // array load cannot leak out while reset is held.
    always_comb begin
        o_mem_resp      = 1'b0;
        o_pmem_read     = 1'b0;
        o_pmem_write    = 1'b0;
        o_pmem_addr_sel = 1'b0;
        o_load_data     = 1'b0;
        o_data_src_sel  = 1'b0;
        o_load_tag      = 1'b0;
        o_load_valid    = 1'b0;
        o_set_dirty     = 1'b0;
        o_clr_dirty     = 1'b0;
        o_load_lru      = 1'b0;
        o_lru_in        = 1'b0;
        if (!i_rst) begin
            case (r_state)
                CHECK: begin
                    if (w_req_hit) begin
                        o_mem_resp = 1'b1;
                        o_load_lru = 1'b1;
                        o_lru_in   = ~i_way_sel;
                        if (i_mem_write) begin
                            o_load_data    = 1'b1;
                            o_data_src_sel = 1'b1;
                            o_set_dirty    = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    o_pmem_write    = 1'b1;
                    o_pmem_addr_sel = 1'b1;
                end
                ALLOCATE: begin
                    o_pmem_read = 1'b1;
                    // The fill is installed in the response cycle, so the
                    // next CHECK cycle sees a hit and completes the request.
                    if (i_pmem_resp) begin
                        o_load_data  = 1'b1;
                        o_load_tag   = 1'b1;
                        o_load_valid = 1'b1;
                        o_clr_dirty  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State sequencing and saturating counters. The LRU bit is only written
    // on a CHECK hit, so i_way_sel keeps naming the same victim throughout
    // WRITEBACK and ALLOCATE. A request dropped mid-miss still finishes its
    // pmem transaction and returns to CHECK, where no response is issued.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= CHECK;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            case (r_state)
                CHECK: begin
                    if (w_req_hit && r_hit_count != CNT_MAX) begin
                        r_hit_count <= r_hit_count + CNT_ONE;
                    end
                    if (w_req_miss) begin
                        if (r_miss_count != CNT_MAX) begin
                            r_miss_count <= r_miss_count + CNT_ONE;
                        end
                        r_state <= (i_valid_sel && i_dirty_sel) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (i_pmem_resp) begin
                        if (r_wb_count != CNT_MAX) begin
                            r_wb_count <= r_wb_count + CNT_ONE;
                        end
                        r_state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (i_pmem_resp) begin
                        r_state <= CHECK;
                    end
                end
                default: r_state <= CHECK;
            endcase
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
    assign o_wb_count   = r_wb_count;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl_fsm
//
// Directed testbench for cache_ctrl_fsm.
//
// A transaction-level model of the controller (which phase of miss handling
// is pending, plus the three counters) predicts every output. The prediction
// is compared on every falling edge.
//
// Hand-computed literal checks in the stimulus pin the model to known values.
//
// Counters are narrowed to 6 bits here, so saturation is reached in a few
// hundred cycles.
// ---------------------------------------------------------------------------
module tb_cache_ctrl_fsm;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          memRead, memWrite, hit, waySel, validSel, dirtySel, pmemResp;
    logic          memResp, pmemRead, pmemWrite, pmemAddrSel;
    logic          loadData, dataSrcSel, loadTag, loadValid;
    logic          setDirty, clrDirty, loadLru, lruIn;
    logic [CW-1:0] hitCount, missCount, wbCount;

    int testsRun    = 0;
    int testsFailed = 0;

    cache_ctrl_fsm #(.CNT_WIDTH(CW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mem_read     (memRead),
        .i_mem_write    (memWrite),
        .o_mem_resp     (memResp),
        .i_hit          (hit),
        .i_way_sel      (waySel),
        .i_valid_sel    (validSel),
        .i_dirty_sel    (dirtySel),
        .o_pmem_read    (pmemRead),
        .o_pmem_write   (pmemWrite),
        .i_pmem_resp    (pmemResp),
        .o_pmem_addr_sel(pmemAddrSel),
        .o_load_data    (loadData),
        .o_data_src_sel (dataSrcSel),
        .o_load_tag     (loadTag),
        .o_load_valid   (loadValid),
        .o_set_dirty    (setDirty),
        .o_clr_dirty    (clrDirty),
        .o_load_lru     (loadLru),
        .o_lru_in       (lruIn),
        .o_hit_count    (hitCount),
        .o_miss_count   (missCount),
        .o_wb_count     (wbCount)
    );

    always #5 clk = ~clk;

    // Every comparison goes through here so the tallies stay in one place.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic h,
                                 input logic way, input logic v, input logic d,
                                 input logic presp);
        memRead  = rd;
        memWrite = wr;
        hit      = h;
        waySel   = way;
        validSel = v;
        dirtySel = d;
        pmemResp = presp;
    endtask

    // Inputs change just after the rising edge; the model samples on the
    // falling edge and commits its next phase for the following rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Transaction-level model: a miss is either waiting on a writeback, then a
    // fill, or just a fill; otherwise the controller is free to serve hits.
    // -----------------------------------------------------------------------
    typedef enum {IDLE, WAIT_WB, WAIT_FILL} modelPhase_t;

    modelPhase_t phase     = IDLE;
    int          expHits   = 0;
    int          expMisses = 0;
    int          expWbs    = 0;
    int          satMax    = (1 << CW) - 1;

    always @(negedge clk) begin : compareProc
        logic req, eResp, ePRead, ePWrite, eAddr, eLData, eSrc, eLTag;
        logic eLValid, eSetD, eClrD, eLLru, eLruIn;
        req     = memRead | memWrite;
        eResp   = 1'b0;
        ePRead  = 1'b0;
        ePWrite = 1'b0;
        eAddr   = 1'b0;
        eLData  = 1'b0;
        eSrc    = 1'b0;
        eLTag   = 1'b0;
        eLValid = 1'b0;
        eSetD   = 1'b0;
        eClrD   = 1'b0;
        eLLru   = 1'b0;
        eLruIn  = 1'b0;
        if (rst) begin
            phase     = IDLE;
            expHits   = 0;
            expMisses = 0;
            expWbs    = 0;
        end else if (phase == IDLE) begin
            if (req && hit) begin
                eResp  = 1'b1;
                eLLru  = 1'b1;
                eLruIn = !waySel;
                if (memWrite) begin
                    eLData = 1'b1;
                    eSrc   = 1'b1;
                    eSetD  = 1'b1;
                end
            end
        end else if (phase == WAIT_WB) begin
            ePWrite = 1'b1;
            eAddr   = 1'b1;
        end else begin
            ePRead = 1'b1;
            if (pmemResp) begin
                eLData  = 1'b1;
                eLTag   = 1'b1;
                eLValid = 1'b1;
                eClrD   = 1'b1;
            end
        end

        checkOutput("mem_resp",      32'(memResp),     32'(eResp));
        checkOutput("pmem_read",     32'(pmemRead),    32'(ePRead));
        checkOutput("pmem_write",    32'(pmemWrite),   32'(ePWrite));
        checkOutput("pmem_addr_sel", 32'(pmemAddrSel), 32'(eAddr));
        checkOutput("load_data",     32'(loadData),    32'(eLData));
        checkOutput("data_src_sel",  32'(dataSrcSel),  32'(eSrc));
        checkOutput("load_tag",      32'(loadTag),     32'(eLTag));
        checkOutput("load_valid",    32'(loadValid),   32'(eLValid));
        checkOutput("set_dirty",     32'(setDirty),    32'(eSetD));
        checkOutput("clr_dirty",     32'(clrDirty),    32'(eClrD));
        checkOutput("load_lru",      32'(loadLru),     32'(eLLru));
        checkOutput("lru_in",        32'(lruIn),       32'(eLruIn));
        checkOutput("hit_count",     32'(hitCount),    expHits);
        checkOutput("miss_count",    32'(missCount),   expMisses);
        checkOutput("wb_count",      32'(wbCount),     expWbs);

        // Advance the model to what the next rising edge should produce.
        if (!rst) begin
            if (phase == IDLE) begin
                if (req && hit) begin
                    expHits = (expHits < satMax) ? expHits + 1 : satMax;
                end else if (req) begin
                    expMisses = (expMisses < satMax) ? expMisses + 1 : satMax;
                    phase = (validSel && dirtySel) ? WAIT_WB : WAIT_FILL;
                end
            end else if (phase == WAIT_WB) begin
                if (pmemResp) begin
                    expWbs = (expWbs < satMax) ? expWbs + 1 : satMax;
                    phase  = WAIT_FILL;
                end
            end else if (pmemResp) begin
                phase = IDLE;
            end
        end
    end

    // The run is a fixed number of cycles; this only guards against a stall.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int readCycles;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit_reset_resp",  32'(memResp),  32'd0);
        checkOutput("lit_reset_hits",  32'(hitCount), 32'd0);
        checkOutput("lit_reset_pread", 32'(pmemRead), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Read hit on way 1
        applyStimulus(1, 0, 1, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("lit_rdhit_resp",  32'(memResp),  32'd1);
        checkOutput("lit_rdhit_lru",   32'(loadLru),  32'd1);
        checkOutput("lit_rdhit_lruin", 32'(lruIn),    32'd0);
        checkOutput("lit_rdhit_ldata", 32'(loadData), 32'd0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit_rdhit_count", 32'(hitCount), 32'd1);
        step();

        // Write hit on way 0
        applyStimulus(0, 1, 1, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("lit_wrhit_resp",  32'(memResp),    32'd1);
        checkOutput("lit_wrhit_ldata", 32'(loadData),   32'd1);
        checkOutput("lit_wrhit_src",   32'(dataSrcSel), 32'd1);
        checkOutput("lit_wrhit_dirty", 32'(setDirty),   32'd1);
        checkOutput("lit_wrhit_lruin", 32'(lruIn),      32'd1);
        step();

        // Clean read miss, fill answered on the third ALLOCATE cycle
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("lit_cmiss_resp", 32'(memResp), 32'd0);
        step();
        readCycles = 0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 0, 0, 0, 1, 0, (c == 2));
            @(negedge clk);
            if (pmemRead) readCycles++;
            if (c == 2) begin
                checkOutput("lit_fill_ltag",   32'(loadTag),   32'd1);
                checkOutput("lit_fill_lvalid", 32'(loadValid), 32'd1);
                checkOutput("lit_fill_ldata",  32'(loadData),  32'd1);
                checkOutput("lit_fill_clrd",   32'(clrDirty),  32'd1);
            end
            step();
        end
        checkOutput("lit_fill_pread_cycles", 32'(readCycles), 32'd3);
        applyStimulus(1, 0, 1, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("lit_cmiss_done_resp", 32'(memResp), 32'd1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit_cmiss_misses", 32'(missCount), 32'd1);
        checkOutput("lit_cmiss_hits",   32'(hitCount),  32'd3);
        checkOutput("lit_cmiss_wbs",    32'(wbCount),   32'd0);
        step();

        // Dirty write miss: writeback (3 cycles) then a one-cycle fill
        applyStimulus(0, 1, 0, 1, 1, 1, 0);
        step();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1, 0, 1, 1, 1, (c == 2));
            @(negedge clk);
            checkOutput("lit_wb_pwrite", 32'(pmemWrite),   32'd1);
            checkOutput("lit_wb_addr",   32'(pmemAddrSel), 32'd1);
            step();
        end
        applyStimulus(0, 1, 0, 1, 1, 1, 1);
        @(negedge clk);
        checkOutput("lit_wbfill_pread", 32'(pmemRead),    32'd1);
        checkOutput("lit_wbfill_addr",  32'(pmemAddrSel), 32'd0);
        step();
        applyStimulus(0, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("lit_wbdone_dirty", 32'(setDirty), 32'd1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit_wb_count", 32'(wbCount),   32'd1);
        checkOutput("lit_wb_miss",  32'(missCount), 32'd2);
        step();

        // Read and write together on a hit behaves as a write
        applyStimulus(1, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("lit_rw_dirty", 32'(setDirty), 32'd1);
        step();

        // Request dropped mid-miss: fill still installed, no response after
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("lit_drop_ltag", 32'(loadTag), 32'd1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit_drop_resp", 32'(memResp), 32'd0);
        step();

        // Reset two cycles into ALLOCATE, then a stray pmem_resp in CHECK
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("lit_rst_pread", 32'(pmemRead),  32'd0);
        checkOutput("lit_rst_miss",  32'(missCount), 32'd0);
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("lit_post_rst_ltag",  32'(loadTag),  32'd0);
        checkOutput("lit_post_rst_pread", 32'(pmemRead), 32'd0);
        checkOutput("lit_post_rst_hits",  32'(hitCount), 32'd0);
        step();

        // Saturation: 65 back-to-back clean misses, each answered at once
        for (int m = 0; m < 65; m++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 1);
            step();
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit_sat_miss", 32'(missCount), 32'h3F);
        step();
        for (int h = 0; h < 70; h++) begin
            applyStimulus(1, 0, 1, h[0], 1, 0, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit_sat_hits", 32'(hitCount), 32'h3F);
        step();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
